// File: rtl/pwm_capture_multi.sv
// Multi-channel RC-style PWM capture: measures each channel's high time, converts it to
// a saturated step value, tracks loss of signal per channel and publishes all channels together.
// Optional macro PWM_GLITCH_FILTER_EN adds a 4-sample majority-free level filter after the synchroniser.
module pwm_capture_multi #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int MIN_CNT      = 49300,
  parameter int STEP_CNT     = 50,
  parameter int OUT_MAX      = 1000,
  parameter int REJ_MIN      = 48000,
  parameter int REJ_MAX      = 110000,
  parameter int UPDATE_CNT   = 2500000,
  parameter int TIMEOUT_CNT  = 5000000,
  parameter int FAILSAFE_VAL = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     pwm_in,
  output logic [13*NUM_CH-1:0]  ratio,
  output logic [NUM_CH-1:0]     valid,
  output logic                  update,
  output logic                  failsafe
);

  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_CNT);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CNT - 1);
  localparam logic [CNT_W-1:0] REJ_MIN_C = CNT_W'(REJ_MIN);
  localparam logic [CNT_W-1:0] REJ_MAX_C = CNT_W'(REJ_MAX);
  localparam logic [CNT_W-1:0] UPD_LAST  = CNT_W'(UPDATE_CNT - 1);
  localparam logic [CNT_W-1:0] TO_C      = CNT_W'(TIMEOUT_CNT);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CNT - 1);
  localparam logic [12:0]      OUT_C     = 13'(OUT_MAX);
  localparam logic [12:0]      FAIL_C    = 13'(FAILSAFE_VAL);

  // Number of cycles after reset before the measured level reflects real input samples
  // rather than the cleared pipeline; until then a channel must not leave SYNC.
`ifdef PWM_GLITCH_FILTER_EN
  localparam logic [2:0] PRIME = 3'd5;
`else
  localparam logic [2:0] PRIME = 3'd2;
`endif

  typedef enum logic [1:0] {SYNC, ARMED, HIGH} state_t;

  logic [NUM_CH-1:0] sync1, sync2, lvl;
  logic [2:0]        prime_cnt;
  logic              primed;
  state_t            st     [NUM_CH];
  state_t            st_nxt [NUM_CH];
  logic [NUM_CH-1:0] rise, fall, acc;
  logic [CNT_W-1:0]  hi_cnt [NUM_CH];
  logic [CNT_W-1:0]  sub_cnt[NUM_CH];
  logic [CNT_W-1:0]  to_cnt [NUM_CH];
  logic [12:0]       step   [NUM_CH];
  logic [12:0]       latest [NUM_CH];
  logic [CNT_W-1:0]  pub_cnt;

  // Two-flop synchroniser for the asynchronous PWM inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_GLITCH_FILTER_EN
  logic [NUM_CH-1:0] hist0, hist1, flt, all_eq;
  assign all_eq = ~((sync1 ^ sync2) | (sync2 ^ hist0) | (hist0 ^ hist1));
  // Level follows the input only once four consecutive samples agree (s1 is the freshest one).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist0 <= '0;
      hist1 <= '0;
      flt   <= '0;
    end else begin
      hist0 <= sync2;
      hist1 <= hist0;
      flt   <= (flt & ~all_eq) | (sync2 & all_eq);
    end
  end
  assign lvl = flt;
`else
  assign lvl = sync2;
`endif

  // Warm-up counter so a pulse already high at reset release is never seen as a low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 prime_cnt <= '0;
    else if (prime_cnt != PRIME) prime_cnt <= prime_cnt + 3'd1;
  end
  assign primed = (prime_cnt == PRIME);

  // Per-channel FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) st[i] <= SYNC;
    end else begin
      for (int i = 0; i < NUM_CH; i++) st[i] <= st_nxt[i];
    end
  end

  // Next-state, edge strobes and the accept window; in ARMED the level was low last cycle,
  // in HIGH it was high, so a level test alone identifies the edge.
  always_comb begin
    rise = '0;
    fall = '0;
    acc  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      st_nxt[i] = st[i];
      case (st[i])
        SYNC:    if (primed && !lvl[i]) st_nxt[i] = ARMED;
        ARMED:   if (lvl[i]) begin
                   st_nxt[i] = HIGH;
                   rise[i]   = 1'b1;
                 end
        HIGH:    if (!lvl[i]) begin
                   st_nxt[i] = ARMED;
                   fall[i]   = 1'b1;
                 end
        default: st_nxt[i] = SYNC;
      endcase
      acc[i] = fall[i] && (hi_cnt[i] >= REJ_MIN_C) && (hi_cnt[i] <= REJ_MAX_C);
    end
  end

  // High-time measurement: step tracks floor((hi_cnt-MIN)/STEP) incrementally, so no divider.
  // Counters are zero whenever a channel is not in HIGH, so the rise cycle counts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        hi_cnt[i]  <= '0;
        sub_cnt[i] <= '0;
        step[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (fall[i]) begin
          hi_cnt[i]  <= '0;
          sub_cnt[i] <= '0;
          step[i]    <= '0;
        end else if ((rise[i] || st[i] == HIGH) && (hi_cnt[i] != '1)) begin
          hi_cnt[i] <= hi_cnt[i] + 1'b1;
          if (hi_cnt[i] >= MIN_C) begin
            if (sub_cnt[i] == STEP_LAST) begin
              sub_cnt[i] <= '0;
              if (step[i] != OUT_C) step[i] <= step[i] + 13'd1;
            end else begin
              sub_cnt[i] <= sub_cnt[i] + 1'b1;
            end
          end
        end
      end
    end
  end

  // Accepted pulses update latest/valid; otherwise the loss-of-signal timer runs and holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        latest[i] <= '0;
        to_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (acc[i]) begin
          latest[i] <= step[i];
          valid[i]  <= 1'b1;
          to_cnt[i] <= '0;
        end else if (to_cnt[i] >= TO_LAST) begin
          to_cnt[i] <= TO_C;
          valid[i]  <= 1'b0;
        end else begin
          to_cnt[i] <= to_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Publish timer: at wrap all channels are snapshotted from the pre-edge latest/valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pub_cnt <= '0;
      update  <= 1'b0;
      ratio   <= '0;
    end else begin
      update <= (pub_cnt == UPD_LAST);
      if (pub_cnt == UPD_LAST) begin
        pub_cnt <= '0;
        for (int i = 0; i < NUM_CH; i++)
          ratio[13*i +: 13] <= valid[i] ? latest[i] : FAIL_C;
      end else begin
        pub_cnt <= pub_cnt + 1'b1;
      end
    end
  end

  // Any lost channel raises failsafe one cycle after its valid bit drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) failsafe <= 1'b0;
    else        failsafe <= ~&valid;
  end

endmodule

// File: doc/pwm_capture_multi.md
PWM_CAPTURE_MULTI -- requirements
Module: pwm_capture_multi

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent PWM input channels (1..8).
REQ-002 Parameter CNT_W, default 32: width of every internal cycle counter.
REQ-003 Parameter MIN_CNT, default 49300: high-time in clk cycles that maps to output 0.
REQ-004 Parameter STEP_CNT, default 50: clk cycles per output LSB above MIN_CNT.
REQ-005 Parameter OUT_MAX, default 1000: output saturation value.
REQ-006 Parameter REJ_MIN, default 48000: pulses with high-time below this are discarded as glitches.
REQ-007 Parameter REJ_MAX, default 110000: pulses with high-time above this are discarded as invalid.
REQ-008 Parameter UPDATE_CNT, default 2500000: publish period in clk cycles.
REQ-009 Parameter TIMEOUT_CNT, default 5000000: cycles without an accepted pulse before a channel is declared lost.
REQ-010 Parameter FAILSAFE_VAL, default 0: value published for a lost channel.
REQ-011 clk  input  1  system clock; all state changes on its rising edge.
REQ-012 rst_n  input  1  asynchronous, active-low reset.
REQ-013 pwm_in  input  NUM_CH  raw asynchronous PWM inputs; bit i is channel i.
REQ-014 ratio  output  13*NUM_CH  published values; bits [13i+12:13i] are channel i.
REQ-015 valid  output  NUM_CH  bit i high when channel i is not lost.
REQ-016 update  output  1  one-cycle pulse on every publish.
REQ-017 failsafe  output  1  high when any valid bit is low.

Function
REQ-018 Each pwm_in bit passes through a 2-flop synchroniser; all edge detection uses the synchronised level.
REQ-019 Per-channel FSM: SYNC (wait for low) -> ARMED (wait for rising edge) -> HIGH (counting) -> back to ARMED on falling edge; after reset a channel starts in SYNC, so a pulse already high at reset is never measured.
REQ-020 In HIGH: hi_cnt increments each cycle, saturating at 2^CNT_W-1; once hi_cnt >= MIN_CNT a sub-counter wraps every STEP_CNT cycles and increments step, saturating at OUT_MAX.
REQ-021 On the falling edge: accept iff REJ_MIN <= hi_cnt <= REJ_MAX; an accepted pulse writes latest[i] = step (0 if hi_cnt < MIN_CNT), i.e. min(floor((hi_cnt-MIN_CNT)/STEP_CNT), OUT_MAX).
REQ-022 A rejected pulse leaves latest[i], valid and the timeout counter unchanged.
REQ-023 latest[i] is written 1 cycle after the synchronised falling edge; no divider is used.
REQ-024 Per-channel timeout counter clears on accept, otherwise increments; reaching TIMEOUT_CNT clears valid[i] and holds the counter there. Accept and timeout in the same cycle: accept wins.
REQ-025 An accepted pulse sets valid[i] in the same cycle latest[i] is written.
REQ-026 Publish counter counts 0..UPDATE_CNT-1 and wraps; at wrap, ratio[i] <= valid[i] ? latest[i] : FAILSAFE_VAL for all channels simultaneously, and update pulses for exactly that cycle.
REQ-027 If an accept and a publish fall in the same cycle, the publish uses the pre-accept latest[i]; the new value appears at the next publish.
REQ-028 failsafe = ~&valid, registered.

Reset
REQ-029 rst_n low asynchronously clears ratio, valid, update, failsafe, latest, all counters and the synchroniser; all FSMs enter SYNC.
REQ-030 Reset asserted mid-pulse discards that pulse; the first measurement after release requires a full low-high-low sequence.

Configuration
REQ-031 Macro PWM_GLITCH_FILTER_EN defined: after the synchroniser, a channel's level changes only after 4 consecutive equal samples, adding 3 cycles of edge latency; high-time measurement is unchanged because both edges are delayed equally.
REQ-032 Macro undefined: no filter; the synchronised level is used directly.

Verification
REQ-033 Ch0 pulse of 74300 high cycles, 20 ms period -> after next publish, ratio[0]=500, valid[0]=1, update pulses once.
REQ-034 High-times of 49300, 48500 and 100000 cycles -> published 0, 0 and 1000 (clamped).
REQ-035 High-times of 47000 and 120000 cycles after an accepted 500 -> ratio stays 500; valid unchanged.
REQ-036 Stop ch2 for > 5000000 cycles -> valid[2]=0, failsafe=1, ratio[2]=FAILSAFE_VAL at next publish; resume pulses -> recovered within one publish.
REQ-037 Falling edge timed so accept coincides with publish wrap -> old value published, new value at following publish.
REQ-038 rst_n pulsed low mid-pulse -> all outputs 0 immediately; that pulse not measured; next full pulse measured correctly.
